// File: rtl/bcd_timer_ctrl_pkg.sv
// Shared definitions for the BCD timer controller: FSM encoding, BCD
// digit bounds and the boundary test used to stop the counter.
package bcd_timer_ctrl_pkg;

  typedef enum logic [1:0] {
    PAUSE = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  // True when one more step in the current direction would wrap the counter.
  function automatic logic at_limit(input logic       up,
                                    input logic [3:0] tens,
                                    input logic [3:0] units);
    return ( up && tens == BCD_MAX && units == BCD_MAX) ||
           (!up && tens == BCD_MIN && units == BCD_MIN);
  endfunction

endpackage

// File: rtl/bcd_timer_ctrl_if.sv
// Signal bundle between the timer controller and its surroundings:
// raw buttons and counter digits in, counter control and status out.
interface bcd_timer_ctrl_if;

  logic       btn_start_n;
  logic       btn_dir_n;
  logic [3:0] num1;
  logic [3:0] num0;
  logic       cnt_en_n;
  logic       cnt_up;
  logic       running;
  logic       done;
  logic       tick;

  // Board / counter side: drives buttons and digits, observes control.
  modport master (
    output btn_start_n, btn_dir_n, num1, num0,
    input  cnt_en_n, cnt_up, running, done, tick
  );

  // Controller side.
  modport slave (
    input  btn_start_n, btn_dir_n, num1, num0,
    output cnt_en_n, cnt_up, running, done, tick
  );

endinterface

// File: rtl/btn_onepulse.sv
// Raw active-low button -> synchronized, debounced level -> one-clk pulse
// on each accepted press. Releases produce nothing.
module btn_onepulse #(
  parameter int DB_CYC = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n_i,
  output logic press_o
);

  localparam int CW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  localparam logic [CW-1:0] STAB_LAST = CW'(DB_CYC - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          level_prev_q;
  logic          press_q;
  logic [CW-1:0] stab_q, stab_d;

  // Accept the synchronized level only after it has disagreed with the
  // current debounced level for DB_CYC consecutive cycles.
  always_comb begin
    level_d = level_q;
    stab_d  = '0;
    if (sync2_q != level_q) begin
      if (stab_q == STAB_LAST) begin
        level_d = sync2_q;
      end else begin
        stab_d = stab_q + CW'(1);
      end
    end
  end

  // Synchronizer, debounce state and press edge detector (1 = released).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      level_q      <= 1'b1;
      level_prev_q <= 1'b1;
      stab_q       <= '0;
      press_q      <= 1'b0;
    end else begin
      sync1_q      <= btn_n_i;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      stab_q       <= stab_d;
      level_prev_q <= level_q;
      press_q      <= level_prev_q & ~level_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/bcd_timer_ctrl.sv
// Run/pause/direction controller for a 2-digit BCD up/down counter.
// Issues one active-low enable per prescaler tick while running and
// parks in DONE instead of letting the counter wrap at 99 / 00.
module bcd_timer_ctrl
  import bcd_timer_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 50000000,
  parameter int DB_CYC   = 1000000
) (
  input logic             clk,
  input logic             rst_n,
  bcd_timer_ctrl_if.slave bus
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic          start_p, dir_p;
  logic          limit;
  state_e        state_q;
  logic [PW-1:0] presc_q;
  logic          cnt_en_n_q, cnt_up_q, running_q, done_q, tick_q;

  btn_onepulse #(.DB_CYC(DB_CYC)) u_btn_start (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_n_i (bus.btn_start_n),
    .press_o (start_p)
  );

  btn_onepulse #(.DB_CYC(DB_CYC)) u_btn_dir (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_n_i (bus.btn_dir_n),
    .press_o (dir_p)
  );

  assign limit = at_limit(cnt_up_q, bus.num1, bus.num0);

  // Controller FSM with prescaler; every output is a register. The
  // prescaler and enable/tick fall back to idle values unless RUN
  // explicitly advances them, so any exit from RUN discards the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PAUSE;
      presc_q    <= '0;
      cnt_en_n_q <= 1'b1;
      cnt_up_q   <= 1'b1;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      cnt_en_n_q <= 1'b1;
      tick_q     <= 1'b0;
      presc_q    <= '0;
      case (state_q)
        PAUSE: begin
          if (start_p) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end else if (dir_p) begin
            cnt_up_q <= ~cnt_up_q;
          end
        end
        RUN: begin
          // start wins over a coinciding tick: pause without stepping.
          if (start_p) begin
            state_q   <= PAUSE;
            running_q <= 1'b0;
          end else if (presc_q == PRESC_LAST) begin
            tick_q <= 1'b1;
            if (limit) begin
              state_q   <= DONE;
              running_q <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              cnt_en_n_q <= 1'b0;
            end
          end else begin
            presc_q <= presc_q + PW'(1);
          end
        end
        DONE: begin
          if (!start_p && dir_p) begin
            cnt_up_q <= ~cnt_up_q;
            state_q  <= PAUSE;
            done_q   <= 1'b0;
          end
        end
        default: begin
          state_q   <= PAUSE;
          running_q <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cnt_en_n = cnt_en_n_q;
  assign bus.cnt_up   = cnt_up_q;
  assign bus.running  = running_q;
  assign bus.done     = done_q;
  assign bus.tick     = tick_q;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Bench for bcd_timer_ctrl with TICK_DIV=4, DB_CYC=3. An attached
// behavioural counter (integer 0..99, wraps like a real counter) steps on
// each enable; expectations come from the timing rules: press pulse
// DB_CYC+3 clks after the raw edge, FSM reacts one clk later, one step
// every TICK_DIV clks after entering RUN.
module tb_bcd_timer_ctrl;

  localparam int TICK_DIV = 4;
  localparam int DB_CYC   = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  bcd_timer_ctrl_if bus();

  bcd_timer_ctrl #(.TICK_DIV(TICK_DIV), .DB_CYC(DB_CYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Attached counter model: value 0..99, loadable while the timer is idle.
  int cnt_val  = 0;
  int en_count = 0;
  int preset_val = 0;
  bit preset_req = 1'b0;

  assign bus.num1 = 4'(cnt_val / 10);
  assign bus.num0 = 4'(cnt_val % 10);

  // Counter steps on the clock edge that sees cnt_en_n low.
  always @(posedge clk) begin
    if (preset_req) begin
      cnt_val <= preset_val;
    end else if (bus.cnt_en_n === 1'b0) begin
      en_count <= en_count + 1;
      if (bus.cnt_up) cnt_val <= (cnt_val == 99) ? 0 : cnt_val + 1;
      else            cnt_val <= (cnt_val == 0) ? 99 : cnt_val - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // An enable must never be low on two consecutive cycles.
  logic prev_en_low = 1'b0;
  always @(negedge clk) begin
    if (rst_n && prev_en_low) check("en_gap", 32'(bus.cnt_en_n), 32'd1);
    prev_en_low <= rst_n && (bus.cnt_en_n === 1'b0);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic preset(input int v);
    preset_val = v;
    preset_req = 1'b1;
    @(negedge clk);
    preset_req = 1'b0;
  endtask

  // Press for 8 clks then release for 8: the FSM acts on the 7th edge.
  task automatic do_press(input bit start, input bit dir);
    if (start) bus.btn_start_n = 1'b0;
    if (dir)   bus.btn_dir_n   = 1'b0;
    step(8);
    bus.btn_start_n = 1'b1;
    bus.btn_dir_n   = 1'b1;
    step(8);
  endtask

  task automatic wait_done(input int limit_cyc);
    int n = 0;
    while (bus.done !== 1'b1 && n < limit_cyc) begin
      @(negedge clk);
      n++;
    end
    check("done_within_bound", 32'(bus.done), 32'd1);
  endtask

  initial begin
    int s, base, len;
    bus.btn_start_n = 1'b1;
    bus.btn_dir_n   = 1'b1;

    // Reset state.
    step(3);
    check("rst_cnt_en_n", 32'(bus.cnt_en_n), 32'd1);
    check("rst_cnt_up",   32'(bus.cnt_up),   32'd1);
    check("rst_running",  32'(bus.running),  32'd0);
    check("rst_done",     32'(bus.done),     32'd0);
    check("rst_tick",     32'(bus.tick),     32'd0);
    rst_n = 1'b1;
    step(2);
    preset(0);
    base = en_count;

    // First start: RUN on edge 7, enables on edges 11 and 15.
    bus.btn_start_n = 1'b0;
    step(6);
    check("start_not_yet", 32'(bus.running), 32'd0);
    step(1);
    check("start_running", 32'(bus.running), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(1);
      if (i == 2) bus.btn_start_n = 1'b1;
      check("first_wait_en", 32'(bus.cnt_en_n), 32'd1);
    end
    step(1);
    check("first_en_low", 32'(bus.cnt_en_n), 32'd0);
    check("first_tick",   32'(bus.tick),     32'd1);
    step(1);
    check("digits_01", 32'(cnt_val), 32'd1);
    step(3);
    check("second_en_low", 32'(bus.cnt_en_n), 32'd0);
    step(1);
    check("digits_02", 32'(cnt_val), 32'd2);
    $display("step first_start: count=%0d enables=%0d", cnt_val, en_count - base);

    // Pause: enable on edge 19 (->03); pause lands on edge 23 together
    // with a tick, so no enable is issued there.
    do_press(1'b1, 1'b0);
    check("pause_running", 32'(bus.running), 32'd0);
    check("pause_count",   32'(cnt_val),     32'd3);
    step(20);
    check("pause_hold", 32'(cnt_val), 32'd3);
    $display("step pause: count=%0d", cnt_val);

    // Random short glitches on either button are ignored.
    for (int g = 0; g < 4; g++) begin
      len = $urandom_range(1, DB_CYC - 1);
      base = en_count;
      if (g % 2 == 0) bus.btn_start_n = 1'b0;
      else            bus.btn_dir_n   = 1'b0;
      step(len);
      bus.btn_start_n = 1'b1;
      bus.btn_dir_n   = 1'b1;
      step(12);
      check("glitch_running", 32'(bus.running), 32'd0);
      check("glitch_dir",     32'(bus.cnt_up),  32'd1);
      check("glitch_no_en",   32'(en_count - base), 32'd0);
      $display("step glitch: len=%0d running=%0d cnt_up=%0d", len, bus.running, bus.cnt_up);
    end

    // Count up from a random start near the top: stops at 99.
    s = $urandom_range(95, 98);
    preset(s);
    base = en_count;
    do_press(1'b1, 1'b0);
    wait_done(200);
    check("up_done_running", 32'(bus.running), 32'd0);
    check("up_final",        32'(cnt_val),     32'd99);
    check("up_steps",        32'(en_count - base), 32'(99 - s));
    step(20);
    check("up_hold", 32'(cnt_val), 32'd99);
    check("up_no_more_en", 32'(en_count - base), 32'(99 - s));
    $display("step count_up: start=%0d final=%0d done=%0d", s, cnt_val, bus.done);

    // start is ignored in DONE.
    do_press(1'b1, 1'b0);
    check("done_ignores_start", 32'(bus.done), 32'd1);

    // dir in DONE: reverse and return to PAUSE.
    do_press(1'b0, 1'b1);
    check("dir_cnt_up",  32'(bus.cnt_up),  32'd0);
    check("dir_done",    32'(bus.done),    32'd0);
    check("dir_running", 32'(bus.running), 32'd0);

    // Count down: two steps within the press window, a third before the
    // pause (which again coincides with a tick).
    base = en_count;
    do_press(1'b1, 1'b0);
    check("down_running", 32'(bus.running), 32'd1);
    check("down_97",      32'(cnt_val),     32'd97);
    do_press(1'b1, 1'b0);
    check("down_paused", 32'(bus.running), 32'd0);
    check("down_96",     32'(cnt_val),     32'd96);
    check("down_steps",  32'(en_count - base), 32'd3);
    $display("step count_down: final=%0d enables=%0d", cnt_val, en_count - base);

    // Down from 00: first tick goes to DONE without stepping.
    preset(0);
    base = en_count;
    do_press(1'b1, 1'b0);
    wait_done(50);
    step(20);
    check("zero_no_wrap", 32'(cnt_val), 32'd0);
    check("zero_no_en",   32'(en_count - base), 32'd0);
    $display("step down_from_zero: count=%0d done=%0d", cnt_val, bus.done);

    // Leave DONE (cnt_up -> 1), then toggle in PAUSE (cnt_up -> 0).
    do_press(1'b0, 1'b1);
    check("leave_done_up", 32'(bus.cnt_up), 32'd1);
    do_press(1'b0, 1'b1);
    check("pause_toggle_up", 32'(bus.cnt_up), 32'd0);

    // Simultaneous start+dir in PAUSE: start wins, direction kept.
    preset(50);
    do_press(1'b1, 1'b1);
    check("both_running", 32'(bus.running), 32'd1);
    check("both_cnt_up",  32'(bus.cnt_up),  32'd0);
    $display("step simultaneous: running=%0d cnt_up=%0d", bus.running, bus.cnt_up);

    // Asynchronous reset mid-run clears outputs immediately.
    step(1);
    rst_n = 1'b0;
    #1;
    check("arst_cnt_en_n", 32'(bus.cnt_en_n), 32'd1);
    check("arst_cnt_up",   32'(bus.cnt_up),   32'd1);
    check("arst_running",  32'(bus.running),  32'd0);
    check("arst_done",     32'(bus.done),     32'd0);
    check("arst_tick",     32'(bus.tick),     32'd0);
    step(3);
    rst_n = 1'b1;
    base = en_count;
    step(12);
    check("post_rst_idle", 32'(bus.running), 32'd0);
    check("post_rst_no_en", 32'(en_count - base), 32'd0);
    $display("step reset_mid_run: running=%0d cnt_up=%0d", bus.running, bus.cnt_up);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
